// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit serializer.
// Optional receive capture is enabled by defining SPI_RX_CAPTURE_EN.
package spi_pkg;

    localparam int SPI_FIFOWIDTH         = 32;
    localparam int SPI_DIVWIDTH          = 8;
    localparam int SPI_WORDLEN_ZERO_BITS = 32;

    // Mode constants are {Cpol, Cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SETUP = 3'd3,
        ST_SHIFT = 3'd4,
        ST_HOLD  = 3'd5,
        ST_GAP   = 3'd6
    } spi_state_t;

    function automatic logic [5:0] word_bits(input logic [4:0] word_len);
        return (word_len == 5'd0) ? 6'(SPI_WORDLEN_ZERO_BITS) : {1'b0, word_len};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Loadable down-counter: one-cycle tick every div+1 cycles, restarting on load.
module spi_clk_div #(
    parameter int DIVWIDTH = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                load,
    input  logic [DIVWIDTH-1:0] div,
    output logic                tick
);

    logic [DIVWIDTH-1:0] cnt_reg;
    logic [DIVWIDTH-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        tick     = 1'b0;
        if (load) begin
            cnt_next = div;
        end else if (cnt_reg == '0) begin
            cnt_next = div;
            tick     = 1'b1;
        end else begin
            cnt_next = cnt_reg - DIVWIDTH'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/spi_tx_serializer.sv
// Pops words from the TX FIFO and shifts them MSB-first onto SCLK/MOSI with SsN framing.
// Define SPI_RX_CAPTURE_EN to capture Miso into RxData.
module spi_tx_serializer
    import spi_pkg::*;
#(
    parameter int FIFOWIDTH = SPI_FIFOWIDTH,
    parameter int DIVWIDTH  = SPI_DIVWIDTH
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 Cpol,
    input  logic                 Cpha,
    input  logic [DIVWIDTH-1:0]  BaudDiv,
    input  logic [4:0]           WordLen,
    input  logic                 FifoEmpty,
    input  logic [FIFOWIDTH-1:0] FifoData,
    output logic                 FifoRead,
    input  logic                 Miso,
    output logic                 Sclk,
    output logic                 Mosi,
    output logic                 SsN,
    output logic                 Busy,
    output logic                 TxDone,
    output logic [FIFOWIDTH-1:0] RxData,
    output logic                 RxValid
);

    spi_state_t state_reg, state_next;

    logic                 cpol_reg;
    logic                 cpha_reg;
    logic [DIVWIDTH-1:0]  div_reg;
    logic [5:0]           nbits_reg;
    logic [6:0]           edge_reg, edge_next;
    logic [FIFOWIDTH-1:0] shift_reg, shift_next;
    logic                 sclk_reg, sclk_next;

    logic                 tick;
    logic                 div_load;
    logic [DIVWIDTH-1:0]  div_sel;
    logic [FIFOWIDTH-1:0] load_word;
    logic [6:0]           edge_num;
    logic                 leading;
    logic                 last_edge;
    logic                 shift_en;

    // The divider restarts in LOAD with the live BaudDiv, then reloads from the latched copy
    assign div_load = (state_reg == ST_LOAD);
    assign div_sel  = div_load ? BaudDiv : div_reg;

    spi_clk_div #(.DIVWIDTH(DIVWIDTH)) u_clk_div (
        .Clock (Clock),
        .Reset (Reset),
        .load  (div_load),
        .div   (div_sel),
        .tick  (tick)
    );

    assign load_word = FifoData << (FIFOWIDTH - int'(word_bits(WordLen)));
    assign edge_num  = edge_reg + 7'd1;
    assign leading   = edge_num[0];
    assign last_edge = (edge_num == {nbits_reg, 1'b0});
    // N-1 data changes per word: trailing edges bar the last, or leading edges bar the first
    assign shift_en  = cpha_reg ? (leading && (edge_num != 7'd1)) : (!leading && !last_edge);

    always_comb begin
        state_next = state_reg;
        sclk_next  = sclk_reg;
        shift_next = shift_reg;
        edge_next  = edge_reg;
        case (state_reg)
            ST_IDLE: begin
                sclk_next = Cpol;
                if (Enable && !FifoEmpty) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                sclk_next  = Cpol;
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                sclk_next  = Cpol;
                shift_next = load_word;
                edge_next  = '0;
                state_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (tick) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick) begin
                    sclk_next = ~sclk_reg;
                    edge_next = edge_num;
                    if (shift_en) shift_next = shift_reg << 1;
                    if (last_edge) state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                sclk_next = cpol_reg;
                if (tick) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (tick) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg <= ST_IDLE;
            sclk_reg  <= 1'b0;
            shift_reg <= '0;
            edge_reg  <= '0;
        end else begin
            state_reg <= state_next;
            sclk_reg  <= sclk_next;
            shift_reg <= shift_next;
            edge_reg  <= edge_next;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cpol_reg  <= 1'b0;
            cpha_reg  <= 1'b0;
            div_reg   <= '0;
            nbits_reg <= '0;
        end else if (state_reg == ST_LOAD) begin
            cpol_reg  <= Cpol;
            cpha_reg  <= Cpha;
            div_reg   <= BaudDiv;
            nbits_reg <= word_bits(WordLen);
        end
    end

    assign FifoRead = (state_reg == ST_LOAD);
    assign Busy     = (state_reg != ST_IDLE);
    assign TxDone   = (state_reg == ST_HOLD) && tick;
    assign SsN      = !((state_reg == ST_SETUP) || (state_reg == ST_SHIFT) || (state_reg == ST_HOLD));
    assign Sclk     = sclk_reg;
    assign Mosi     = shift_reg[FIFOWIDTH-1];

`ifdef SPI_RX_CAPTURE_EN
    logic [FIFOWIDTH-1:0] rx_shift_reg, rx_shift_next;
    logic [FIFOWIDTH-1:0] rx_data_reg;
    logic                 sample_en;

    assign sample_en = cpha_reg ? !leading : leading;

    always_comb begin
        rx_shift_next = rx_shift_reg;
        if (state_reg == ST_LOAD) begin
            rx_shift_next = '0;
        end else if ((state_reg == ST_SHIFT) && tick && sample_en) begin
            rx_shift_next = {rx_shift_reg[FIFOWIDTH-2:0], Miso};
        end
    end

    // Edge 2N is the final edge, so every sample is in place when it occurs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
        end else begin
            rx_shift_reg <= rx_shift_next;
            if ((state_reg == ST_SHIFT) && tick && last_edge) rx_data_reg <= rx_shift_next;
        end
    end

    assign RxData  = rx_data_reg;
    assign RxValid = TxDone;
`else
    logic unused_miso;
    assign unused_miso = Miso;
    assign RxData      = '0;
    assign RxValid     = 1'b0;
`endif

endmodule
